// File: rtl/alu_share_arbiter_if.sv
// Request/grant and result bundle between two datapath clients and the shared ALU arbiter.
// The master side is the pair of requesters; the slave side is the arbiter.
interface alu_share_arbiter_if;
    logic       req0;
    logic [2:0] op0;
    logic [7:0] a0;
    logic [7:0] b0;
    logic       req1;
    logic [2:0] op1;
    logic [7:0] a1;
    logic [7:0] b1;
    logic       gnt0;
    logic       gnt1;
    logic       busy;
    logic       res_valid;
    logic       res_id;
    logic [7:0] result;
    logic       cout;
    logic       ovf;
    logic       zero;
    logic       err;

    modport master (
        output req0, op0, a0, b0, req1, op1, a1, b1,
        input  gnt0, gnt1, busy, res_valid, res_id, result, cout, ovf, zero, err
    );

    modport slave (
        input  req0, op0, a0, b0, req1, op1, a1, b1,
        output gnt0, gnt1, busy, res_valid, res_id, result, cout, ovf, zero, err
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one 8-bit ALU between two requesters; operands are held
// for LAT settle cycles before the result, flags and owner ID are registered.
module alu_share_arbiter #(
    parameter int unsigned LAT = 2
) (
    input  logic                clk,
    input  logic                res,
    alu_share_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(LAT - 1);

    state_t     state_r;
    state_t     state_s;
    logic       grant_s;
    logic       grant_id_s;
    logic [2:0] op_sel_s;
    logic [7:0] a_sel_s;
    logic [7:0] b_sel_s;
    logic [11:0] alu_s;

    logic       ptr_r;
    logic       owner_r;
    logic [2:0] op_r;
    logic [7:0] a_r;
    logic [7:0] b_r;
    logic [3:0] cnt_r;
    logic       gnt0_r;
    logic       gnt1_r;
    logic       busy_r;
    logic       res_valid_r;
    logic       res_id_r;
    logic [7:0] result_r;
    logic       cout_r;
    logic       ovf_r;
    logic       zero_r;
    logic       err_r;

    // Packed as {err, zero, ovf, cout, result[7:0]}; SUB uses A + ~B + 1 so cout is the inverted carry (borrow).
    function automatic logic [11:0] alu_eval(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [8:0] sum;
        logic [7:0] r;
        logic       c;
        logic       v;
        logic       e;
        sum = 9'd0;
        r   = 8'd0;
        c   = 1'b0;
        v   = 1'b0;
        e   = 1'b0;
        case (op)
            3'b000: begin
                sum = {1'b0, a} + {1'b0, b};
                r   = sum[7:0];
                c   = sum[8];
                v   = (a[7] == b[7]) && (r[7] != a[7]);
            end
            3'b001: begin
                sum = {1'b0, a} + {1'b0, ~b} + 9'd1;
                r   = sum[7:0];
                c   = ~sum[8];
                v   = (a[7] != b[7]) && (r[7] != a[7]);
            end
            3'b010:  r = a & b;
            3'b011:  r = a | b;
            3'b100:  r = a ^ b;
            3'b101:  r = ~a;
            default: e = 1'b1;
        endcase
        return {e, (r == 8'd0), v, c, r};
    endfunction

    // State register.
    always_ff @(posedge clk) begin
        if (res) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state and arbitration decision; ptr breaks ties when both requesters are pending.
    always_comb begin
        state_s    = state_r;
        grant_s    = 1'b0;
        grant_id_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.req0 && bus.req1) begin
                    grant_s    = 1'b1;
                    grant_id_s = ptr_r;
                    state_s    = EXEC;
                end else if (bus.req0) begin
                    grant_s    = 1'b1;
                    grant_id_s = 1'b0;
                    state_s    = EXEC;
                end else if (bus.req1) begin
                    grant_s    = 1'b1;
                    grant_id_s = 1'b1;
                    state_s    = EXEC;
                end else begin
                    state_s    = IDLE;
                end
            end
            EXEC: begin
                if (cnt_r == 4'd0) begin
                    state_s = DONE;
                end else begin
                    state_s = EXEC;
                end
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Operand selection for the winner and evaluation of the held operands.
    always_comb begin
        op_sel_s = 3'd0;
        a_sel_s  = 8'd0;
        b_sel_s  = 8'd0;
        if (grant_id_s) begin
            op_sel_s = bus.op1;
            a_sel_s  = bus.a1;
            b_sel_s  = bus.b1;
        end else begin
            op_sel_s = bus.op0;
            a_sel_s  = bus.a0;
            b_sel_s  = bus.b0;
        end
        alu_s = alu_eval(op_r, a_r, b_r);
    end

    // Datapath: operand capture, settle counter, result/flag registers, grant and strobe pulses.
    always_ff @(posedge clk) begin
        if (res) begin
            ptr_r       <= 1'b0;
            owner_r     <= 1'b0;
            op_r        <= 3'd0;
            a_r         <= 8'd0;
            b_r         <= 8'd0;
            cnt_r       <= 4'd0;
            gnt0_r      <= 1'b0;
            gnt1_r      <= 1'b0;
            busy_r      <= 1'b0;
            res_valid_r <= 1'b0;
            res_id_r    <= 1'b0;
            result_r    <= 8'd0;
            cout_r      <= 1'b0;
            ovf_r       <= 1'b0;
            zero_r      <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            gnt0_r      <= grant_s && !grant_id_s;
            gnt1_r      <= grant_s && grant_id_s;
            busy_r      <= (state_s != IDLE);
            res_valid_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (grant_s) begin
                        op_r    <= op_sel_s;
                        a_r     <= a_sel_s;
                        b_r     <= b_sel_s;
                        owner_r <= grant_id_s;
                        cnt_r   <= CNT_INIT;
                    end else begin
                        cnt_r   <= cnt_r;
                    end
                end
                EXEC: begin
                    if (cnt_r != 4'd0) begin
                        cnt_r <= cnt_r - 4'd1;
                    end else begin
                        {err_r, zero_r, ovf_r, cout_r, result_r} <= alu_s;
                        res_id_r    <= owner_r;
                        res_valid_r <= 1'b1;
                    end
                end
                DONE: begin
                    // The requester that was not just served gets priority on the next tie.
                    ptr_r <= ~owner_r;
                end
                default: begin
                    cnt_r <= 4'd0;
                end
            endcase
        end
    end

    assign bus.gnt0      = gnt0_r;
    assign bus.gnt1      = gnt1_r;
    assign bus.busy      = busy_r;
    assign bus.res_valid = res_valid_r;
    assign bus.res_id    = res_id_r;
    assign bus.result    = result_r;
    assign bus.cout      = cout_r;
    assign bus.ovf       = ovf_r;
    assign bus.zero      = zero_r;
    assign bus.err       = err_r;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed and randomized bench for alu_share_arbiter: one LAT=2 and one LAT=1 instance,
// with expectations taken from an arithmetic ALU model and a last-served arbitration model.
module tb_alu_share_arbiter;

    logic       clk = 1'b0;
    logic       res = 1'b1;
    logic       req0 = 1'b0;
    logic       req1 = 1'b0;
    logic [2:0] op0 = 3'd0;
    logic [2:0] op1 = 3'd0;
    logic [7:0] a0 = 8'd0;
    logic [7:0] b0 = 8'd0;
    logic [7:0] a1 = 8'd0;
    logic [7:0] b1 = 8'd0;
    int         sel = 0;
    int         n_checks = 0;
    int         n_fail = 0;
    bit         ptr_m [2];

    logic        gnt0_s;
    logic        gnt1_s;
    logic        busy_s;
    logic        res_valid_s;
    logic        res_id_s;
    logic [11:0] flags_s;

    alu_share_arbiter_if bus_a ();
    alu_share_arbiter_if bus_b ();

    alu_share_arbiter #(.LAT(2)) u_dut_lat2 (.clk(clk), .res(res), .bus(bus_a));
    alu_share_arbiter #(.LAT(1)) u_dut_lat1 (.clk(clk), .res(res), .bus(bus_b));

    always #5 clk = ~clk;

    assign bus_a.req0 = (sel == 0) ? req0 : 1'b0;
    assign bus_a.req1 = (sel == 0) ? req1 : 1'b0;
    assign bus_b.req0 = (sel == 1) ? req0 : 1'b0;
    assign bus_b.req1 = (sel == 1) ? req1 : 1'b0;
    assign bus_a.op0 = op0;
    assign bus_a.a0  = a0;
    assign bus_a.b0  = b0;
    assign bus_a.op1 = op1;
    assign bus_a.a1  = a1;
    assign bus_a.b1  = b1;
    assign bus_b.op0 = op0;
    assign bus_b.a0  = a0;
    assign bus_b.b0  = b0;
    assign bus_b.op1 = op1;
    assign bus_b.a1  = a1;
    assign bus_b.b1  = b1;

    assign gnt0_s      = (sel == 1) ? bus_b.gnt0 : bus_a.gnt0;
    assign gnt1_s      = (sel == 1) ? bus_b.gnt1 : bus_a.gnt1;
    assign busy_s      = (sel == 1) ? bus_b.busy : bus_a.busy;
    assign res_valid_s = (sel == 1) ? bus_b.res_valid : bus_a.res_valid;
    assign res_id_s    = (sel == 1) ? bus_b.res_id : bus_a.res_id;
    assign flags_s     = (sel == 1) ? {bus_b.err, bus_b.zero, bus_b.ovf, bus_b.cout, bus_b.result}
                                    : {bus_a.err, bus_a.zero, bus_a.ovf, bus_a.cout, bus_a.result};

    // Reference ALU from integer arithmetic; returns {err, zero, ovf, cout, result}.
    function automatic logic [11:0] alu_ref(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        int ua, ub, sa, sb, s, ss;
        logic [7:0] r;
        logic c, v, e;
        ua = int'(a);
        ub = int'(b);
        sa = (ua > 127) ? ua - 256 : ua;
        sb = (ub > 127) ? ub - 256 : ub;
        r = 8'd0; c = 1'b0; v = 1'b0; e = 1'b0;
        case (op)
            3'd0: begin
                s = ua + ub; ss = sa + sb;
                r = 8'(s % 256); c = (s > 255); v = (ss > 127) || (ss < -128);
            end
            3'd1: begin
                s = ua - ub + 256; ss = sa - sb;
                r = 8'(s % 256); c = (ua < ub); v = (ss > 127) || (ss < -128);
            end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: r = ~a;
            default: e = 1'b1;
        endcase
        return {e, (r == 8'd0), v, c, r};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        res  = 1'b1;
        req0 = 1'b0;
        req1 = 1'b0;
        tick();
        tick();
        check("rst_busy", 32'(busy_s), 32'd0);
        check("rst_gnt", 32'({gnt0_s, gnt1_s}), 32'd0);
        check("rst_res_valid", 32'(res_valid_s), 32'd0);
        check("rst_flags", 32'(flags_s), 32'd0);
        check("rst_res_id", 32'(res_id_s), 32'd0);
        res = 1'b0;
        ptr_m[0] = 1'b0;
        ptr_m[1] = 1'b0;
    endtask

    // One full arbitration: sample, grant, settle, result, return to IDLE.
    task automatic arb_round(input bit r0, input bit r1);
        int w;
        int lat;
        logic [11:0] exp;
        lat = (sel == 1) ? 1 : 2;
        if (r0 && r1) w = int'(ptr_m[sel]);
        else if (r0)  w = 0;
        else          w = 1;
        exp  = (w == 0) ? alu_ref(op0, a0, b0) : alu_ref(op1, a1, b1);
        req0 = r0;
        req1 = r1;
        tick();
        check("gnt0", 32'(gnt0_s), 32'(w == 0));
        check("gnt1", 32'(gnt1_s), 32'(w == 1));
        check("busy_exec", 32'(busy_s), 32'd1);
        // The winner drops req and scrambles its operands; the held copy must be used.
        if (w == 0) begin
            req0 = 1'b0; op0 = 3'($urandom); a0 = 8'($urandom); b0 = 8'($urandom);
        end else begin
            req1 = 1'b0; op1 = 3'($urandom); a1 = 8'($urandom); b1 = 8'($urandom);
        end
        for (int k = 1; k <= lat; k++) begin
            tick();
            check("gnt_pulse", 32'({gnt0_s, gnt1_s}), 32'd0);
            check("res_valid_time", 32'(res_valid_s), 32'(k == lat));
        end
        check("result_flags", 32'(flags_s), 32'(exp));
        check("res_id", 32'(res_id_s), 32'(w));
        tick();
        check("res_valid_drop", 32'(res_valid_s), 32'd0);
        check("busy_idle", 32'(busy_s), 32'd0);
        check("result_hold", 32'(flags_s), 32'(exp));
        ptr_m[sel] = (w == 0);
    endtask

    initial begin
        int v;
        sel = 0;
        do_reset();

        // ADD with signed overflow into 0x80
        op0 = 3'b000; a0 = 8'h7F; b0 = 8'h01;
        arb_round(1'b1, 1'b0);
        check("add_7f_01", 32'(flags_s), 32'({1'b0, 1'b0, 1'b1, 1'b0, 8'h80}));

        // SUB with borrow, then SUB with signed overflow
        op1 = 3'b001; a1 = 8'h05; b1 = 8'h07;
        arb_round(1'b0, 1'b1);
        check("sub_05_07", 32'(flags_s), 32'({1'b0, 1'b0, 1'b0, 1'b1, 8'hFE}));
        op1 = 3'b001; a1 = 8'h80; b1 = 8'h01;
        arb_round(1'b0, 1'b1);
        check("sub_80_01", 32'(flags_s), 32'({1'b0, 1'b0, 1'b1, 1'b0, 8'h7F}));

        // Contention straight after reset, then continuous contention alternates
        do_reset();
        op0 = 3'b010; a0 = 8'hF0; b0 = 8'h3C;
        op1 = 3'b011; a1 = 8'h0F; b1 = 8'h30;
        arb_round(1'b1, 1'b1);
        check("tie_first_id", 32'(res_id_s), 32'd0);
        arb_round(1'b0, 1'b1);
        check("tie_second_id", 32'(res_id_s), 32'd1);
        for (int i = 0; i < 4; i++) begin
            arb_round(1'b1, 1'b1);
            check("alternate_id", 32'(res_id_s), 32'(i % 2));
        end

        // Illegal opcode, then XOR on the same operands
        op0 = 3'b110; a0 = 8'hAA; b0 = 8'h55;
        arb_round(1'b1, 1'b0);
        check("illegal_110", 32'(flags_s), 32'({1'b1, 1'b1, 1'b0, 1'b0, 8'h00}));
        op0 = 3'b100; a0 = 8'hAA; b0 = 8'h55;
        arb_round(1'b1, 1'b0);
        check("xor_aa_55", 32'(flags_s), 32'({1'b0, 1'b0, 1'b0, 1'b0, 8'hFF}));

        // Reset wins over a request in the same cycle
        res = 1'b1; req0 = 1'b1;
        tick();
        check("rst_over_req_gnt", 32'(gnt0_s), 32'd0);
        check("rst_over_req_busy", 32'(busy_s), 32'd0);
        res = 1'b0; req0 = 1'b0;
        ptr_m[0] = 1'b0; ptr_m[1] = 1'b0;

        // Leave ptr at 1, then reset one cycle into EXEC
        op0 = 3'b000; a0 = 8'h01; b0 = 8'h02;
        arb_round(1'b1, 1'b0);
        req0 = 1'b1;
        tick();
        check("pre_rst_gnt0", 32'(gnt0_s), 32'd1);
        req0 = 1'b0;
        res  = 1'b1;
        tick();
        check("mid_rst_busy", 32'(busy_s), 32'd0);
        check("mid_rst_flags", 32'(flags_s), 32'd0);
        res = 1'b0;
        ptr_m[0] = 1'b0; ptr_m[1] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("mid_rst_no_valid", 32'(res_valid_s), 32'd0);
        end
        op0 = 3'b101; a0 = 8'h5A; b0 = 8'h00;
        op1 = 3'b000; a1 = 8'h10; b1 = 8'h20;
        arb_round(1'b1, 1'b1);
        check("post_rst_ptr0", 32'(res_id_s), 32'd0);
        arb_round(1'b0, 1'b1);

        // LAT=1 instance: FF + 01 wraps to zero with carry
        sel = 1;
        do_reset();
        op0 = 3'b000; a0 = 8'hFF; b0 = 8'h01;
        arb_round(1'b1, 1'b0);
        check("lat1_add_ff_01", 32'(flags_s), 32'({1'b0, 1'b1, 1'b0, 1'b1, 8'h00}));

        // Randomized rounds across both instances
        for (int i = 0; i < 40; i++) begin
            sel = int'($urandom_range(0, 1));
            op0 = 3'($urandom); a0 = 8'($urandom); b0 = 8'($urandom);
            op1 = 3'($urandom); a1 = 8'($urandom); b1 = 8'($urandom);
            v = int'($urandom_range(1, 3));
            arb_round(v[0], v[1]);
        end
        req0 = 1'b0;
        req1 = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
